// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame geometry, log2/bit-reversal helpers,
// the packed {re, im} sample type and the reorder read-FSM state type.
package fft_pkg;

    localparam int FFT_N     = 1024;
    localparam int FFT_WIDTH = 14;

    typedef struct packed {
        logic [FFT_WIDTH-1:0] re;
        logic [FFT_WIDTH-1:0] im;
    } sample_t;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Reverses the low 'width' bits of v; bits above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < width; i++) r[i] = v[width-1-i];
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The address MSB selects the ping-pong bank.
module fft_reorder_ram #(
    parameter int AW = 11,
    parameter int DW = 28
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong bit-reversal reorder buffer: bit-reversed FFT frames in, natural-order bins out.
// Define FFT_REORDER_HALF_EN to emit only bins 0..N/2 per frame (real-input spectra).
module fft_reorder
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                di_en,
    input  logic [WIDTH-1:0]    di_re,
    input  logic [WIDTH-1:0]    di_im,
    output logic                do_en,
    output logic [WIDTH-1:0]    do_re,
    output logic [WIDTH-1:0]    do_im,
    output logic [clog2(N)-1:0] do_idx,
    output logic                frame_err
);

    localparam int AW = clog2(N);
    localparam logic [AW-1:0] WR_LAST = AW'(N - 1);
`ifdef FFT_REORDER_HALF_EN
    localparam logic [AW-1:0] RD_LAST = AW'(N / 2);
`else
    localparam logic [AW-1:0] RD_LAST = AW'(N - 1);
`endif

    // Same layout as fft_pkg::sample_t, but sized by this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } word_t;

    logic [AW-1:0] wr_count_reg;
    logic          wr_bank_reg;
    logic          frame_done;
    logic          frame_abort;

    assign frame_done  = di_en && (wr_count_reg == WR_LAST);
    assign frame_abort = !di_en && (wr_count_reg != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_count_reg <= '0;
            wr_bank_reg  <= 1'b0;
        end else if (di_en) begin
            wr_count_reg <= wr_count_reg + 1'b1;
            if (frame_done) wr_bank_reg <= !wr_bank_reg;
        end else begin
            wr_count_reg <= '0;
        end
    end

    rd_state_t     state_reg;
    logic [AW-1:0] rd_count_reg;
    logic          rd_bank_reg;
    logic          rd_last;
    logic          rd_issue;

    assign rd_last  = (rd_count_reg == RD_LAST);
    assign rd_issue = (state_reg == RD_READ);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= RD_IDLE;
            rd_count_reg <= '0;
            rd_bank_reg  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            // A frame completing while a burst is still mid-way cannot be legal input.
            frame_err <= frame_abort || (frame_done && rd_issue && !rd_last);
            case (state_reg)
                RD_IDLE: begin
                    if (frame_done) begin
                        state_reg    <= RD_READ;
                        rd_bank_reg  <= wr_bank_reg;
                        rd_count_reg <= '0;
                    end
                end
                RD_READ: begin
                    if (rd_last) begin
                        rd_count_reg <= '0;
                        if (frame_done) rd_bank_reg <= wr_bank_reg;
                        else            state_reg   <= RD_IDLE;
                    end else begin
                        rd_count_reg <= rd_count_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    word_t         wr_word;
    word_t         rd_word;
    logic [AW:0]   rd_addr;

    assign wr_word = '{re: di_re, im: di_im};
    assign rd_addr = {rd_bank_reg, AW'(bitrev(32'(rd_count_reg), AW))};

    fft_reorder_ram #(
        .AW (AW + 1),
        .DW (2 * WIDTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (di_en),
        .wr_addr ({wr_bank_reg, wr_count_reg}),
        .wr_data (wr_word),
        .rd_en   (rd_issue),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    logic          rd_valid_reg;
    logic [AW-1:0] rd_idx_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
            rd_idx_reg   <= '0;
            do_en        <= 1'b0;
            do_re        <= '0;
            do_im        <= '0;
            do_idx       <= '0;
        end else begin
            rd_valid_reg <= rd_issue;
            if (rd_issue) rd_idx_reg <= rd_count_reg;
            do_en <= rd_valid_reg;
            if (rd_valid_reg) begin
                do_re  <= rd_word.re;
                do_im  <= rd_word.im;
                do_idx <= rd_idx_reg;
            end
        end
    end

endmodule

// File: doc/fft_reorder.md
# fft_reorder

Bit-reversal reorder buffer for the streaming FFT output. It consumes the bit-reversed sample stream produced by the radix-2² SDF pipeline and emits each N-point frame in natural bin order, with a bin index for the downstream mel filterbank. Storage is ping-pong: one bank fills while the other bank drains.

## Interface
- N, 1024: FFT points per frame; power of 2, at least 4.
- WIDTH, 14: sample width per component, two's complement.
- clock  in  1  master clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- di_en  in  1  input sample valid; a frame is N consecutive high cycles.
- di_re  in  WIDTH  input real part, in bit-reversed order.
- di_im  in  WIDTH  input imaginary part.
- do_en  out  1  output sample valid.
- do_re  out  WIDTH  output real part, in natural order.
- do_im  out  WIDTH  output imaginary part.
- do_idx  out  log2(N)  bin index of the current output sample.
- frame_err  out  1  one-cycle pulse when an input frame is aborted.

## Operation
- Storage is 2 banks of N words. Each word is {re, im}, 2·WIDTH bits.
- Write side:
  - wr_count (log2 N bits) counts accepted samples; wr_bank selects the bank.
  - Each cycle with di_en=1 writes di at address wr_count in bank wr_bank and increments wr_count.
  - When wr_count==N-1 is written: wr_count wraps to 0, wr_bank toggles, and a one-cycle frame_done is raised.
  - di_en=0 with wr_count≠0: the frame is aborted. wr_count clears to 0, wr_bank is unchanged, frame_err pulses on the next cycle, and the partial frame is discarded.
  - di_en=0 with wr_count==0: idle, no error.
- Read FSM has two states, IDLE and READ.
  - IDLE→READ on frame_done. rd_bank is set to the bank just completed and rd_count to 0.
  - In READ, each cycle issues address bitrev(rd_count) in bank rd_bank and increments rd_count.
  - READ→IDLE after the address for rd_count==N-1 is issued. If frame_done occurs in the same cycle, the FSM goes READ→READ on the new bank with no gap.
- Legal input cannot overlap reads, because a full write takes at least N cycles. If frame_done arrives while rd_count≠N-1, it is ignored and frame_err pulses.
- bitrev reverses all log2(N) bits.
- Data is never modified: no scaling and no rounding.

## Timing
- Reset values: do_en=0, do_re=0, do_im=0, do_idx=0, frame_err=0. Also wr_count=0, wr_bank=0, rd_count=0, FSM=IDLE.
- RAM contents are not cleared by reset.
- Reset mid-frame discards both the write frame and the read frame.
- RAM read is registered, and the output register follows it.
- Latency: the last sample of a frame is written at cycle t; the first output (do_idx=0) has do_en=1 at t+2.
- Output burst: do_en is high for N consecutive cycles, do_idx = 0..N-1.
- Back-to-back input frames produce back-to-back output bursts with no idle cycle.
- When do_en=0, do_re, do_im and do_idx hold their last values.
- A write and a read never target the same bank in the same cycle.

## Configuration
- FFT_REORDER_HALF_EN defined:
  - The read burst stops after rd_count==N/2, giving N/2+1 outputs, bins 0..N/2, for real-input spectra.
  - READ→IDLE follows the address for bin N/2.
  - A frame_done arriving in the remaining N/2-1 cycles starts a new burst normally; this is not an error.
- FFT_REORDER_HALF_EN undefined: a full N-sample burst, as described above.

## Structure
- Shared package fft_pkg holds:
  - default N and WIDTH;
  - the log2 constant function;
  - the bitrev function, parameterised by width;
  - the packed sample typedef {re, im}.
- Sub-module fft_reorder_ram:
  - simple dual-port, 2N×2·WIDTH;
  - one write port and one registered read port;
  - address MSB is the bank bit.
- The read FSM, counters and output register stay in fft_reorder.

## Test plan
- Single frame, N=16, sample k = (re k, im −k):
  - output re sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with im the negation;
  - do_idx is 0..15;
  - the first do_en comes 2 cycles after the last di_en.
- Three back-to-back frames, N=16: do_en stays high for 48 continuous cycles and each frame reorders correctly; bank ping-pong is verified by distinct per-frame offsets.
- Abort: di_en drops after 5 samples.
  - frame_err pulses once, and there is no output;
  - the next full frame outputs correctly from bin 0.
- Reset asserted mid-read, at output bin 7:
  - do_en drops to 0 asynchronously, and all outputs read 0;
  - after release, a new frame outputs correctly.
- Gapped frames (20 idle cycles between frames): each frame gives exactly 16 outputs, and outputs hold value while do_en=0.
- With FFT_REORDER_HALF_EN, N=16: 9 outputs, bins 0..8, re = 0,8,4,12,2,10,6,14,1; back-to-back frames produce no frame_err.
